// File: rtl/rs_bank_pkg.sv
// Shared types for the reservation-station bank: ALU function codes, FU classes and the entry record.
// The physical-register and ROB sizes are the shared defines; the guards let any file supply them first.
`ifndef PRN_SIZE
`define PRN_SIZE 64
`endif
`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif

package rs_bank_pkg;

   localparam int PRN_W = $clog2(`PRN_SIZE);
   localparam int ROB_W = $clog2(`ROB_SIZE);

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } ALU_FUNC;

   typedef enum logic [1:0] {
      FU_ALU  = 2'd0,
      FU_MULT = 2'd1,
      FU_MEM  = 2'd2
   } fu_class_e;

   // While an operand is not ready, the low PRN_W bits of its data field hold the awaited tag.
   typedef struct packed {
      logic             valid;
      logic [63:0]      opa;
      logic             opa_rdy;
      logic [63:0]      opb;
      logic             opb_rdy;
      logic [PRN_W-1:0] dest;
      logic [ROB_W-1:0] rob_idx;
      logic [5:0]       op_type;
      ALU_FUNC          alu_func;
      fu_class_e        fu_sel;
   } rs_entry_t;

endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot: holds an instruction and snoops the CDBs for its missing operands.
module rs_entry
   import rs_bank_pkg::*;
#(
   parameter int NUM_CDB = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear_i,
   input  logic             load_i,
   input  rs_entry_t        load_entry_i,
   input  logic [63:0]      cdb_data_i [NUM_CDB],
   input  logic [PRN_W-1:0] cdb_tag_i [NUM_CDB],
   input  logic [NUM_CDB-1:0] cdb_valid_i,
   output rs_entry_t        entry_o,
   output logic             ready_o
);

   rs_entry_t entry_q, entry_d, cand;

   // Wakeup acts on whatever the slot will hold, so a same-cycle dispatch is bypassed; the
   // descending scan lets the lowest-numbered matching CDB be the last writer.
   always_comb begin
      cand    = load_i ? load_entry_i : entry_q;
      entry_d = cand;
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
         if (cdb_valid_i[k] && !cand.opa_rdy && (cdb_tag_i[k] == cand.opa[PRN_W-1:0])) begin
            entry_d.opa     = cdb_data_i[k];
            entry_d.opa_rdy = 1'b1;
         end
         if (cdb_valid_i[k] && !cand.opb_rdy && (cdb_tag_i[k] == cand.opb[PRN_W-1:0])) begin
            entry_d.opb     = cdb_data_i[k];
            entry_d.opb_rdy = 1'b1;
         end
      end
      if (clear_i) begin
         entry_d.valid = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         entry_q <= '0;
      end else begin
         entry_q <= entry_d;
      end
   end

   assign entry_o = entry_q;
   assign ready_o = entry_q.valid && entry_q.opa_rdy && entry_q.opb_rdy;

endmodule

// File: rtl/rs_bank.sv
// Reservation-station bank: two-lane dispatch into free slots, CDB wakeup, and one issue per FU class
// per cycle chosen by lowest slot index.
module rs_bank
   import rs_bank_pkg::*;
#(
   parameter int RS_SIZE = 8,
   parameter int NUM_CDB = 2,
   parameter int NUM_FU  = 3,
   localparam int FU_SEL_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
   localparam int CNT_W    = $clog2(RS_SIZE + 1)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [1:0]          rs_load_in,
   input  logic [PRN_W-1:0]    rs_dest_in [2],
   input  logic [63:0]         rs_opa_in [2],
   input  logic [63:0]         rs_opb_in [2],
   input  logic [1:0]          rs_opa_valid,
   input  logic [1:0]          rs_opb_valid,
   input  logic [5:0]          rs_op_type_in [2],
   input  ALU_FUNC             rs_alu_func [2],
   input  logic [ROB_W-1:0]    rs_rob_idx_in [2],
   input  logic [FU_SEL_W-1:0] rs_fu_sel_in [2],
   input  logic [63:0]         rs_cdb_in [NUM_CDB],
   input  logic [PRN_W-1:0]    rs_cdb_tag [NUM_CDB],
   input  logic [NUM_CDB-1:0]  rs_cdb_valid,
   input  logic [NUM_FU-1:0]   fu_available,
   input  logic                squash,
   output logic [63:0]         rs_opa_out [NUM_FU],
   output logic [63:0]         rs_opb_out [NUM_FU],
   output logic [PRN_W-1:0]    rs_dest_tag_out [NUM_FU],
   output logic [ROB_W-1:0]    rs_rob_idx_out [NUM_FU],
   output logic [5:0]          rs_op_type_out [NUM_FU],
   output ALU_FUNC             rs_alu_func_out [NUM_FU],
   output logic [NUM_FU-1:0]   rs_out_valid,
   output logic [CNT_W-1:0]    rs_free_count,
   output logic                rs_full
);

   localparam int IDX_W = $clog2(RS_SIZE);

   rs_entry_t          entries [RS_SIZE];
   rs_entry_t          load_entry [RS_SIZE];
   rs_entry_t          lane_entry [2];
   logic [RS_SIZE-1:0] ready, load, clear, issue_mask;
   logic [1:0]         free_found, lane_go;
   logic [IDX_W-1:0]   free_idx [2];
   logic [NUM_FU-1:0]  sel_found;
   logic [IDX_W-1:0]   sel_idx [NUM_FU];
   logic               dispatch_ok;

   logic [63:0]        opa_q [NUM_FU];
   logic [63:0]        opb_q [NUM_FU];
   logic [PRN_W-1:0]   dest_q [NUM_FU];
   logic [ROB_W-1:0]   rob_q [NUM_FU];
   logic [5:0]         op_type_q [NUM_FU];
   ALU_FUNC            alu_func_q [NUM_FU];
   logic [NUM_FU-1:0]  out_valid_q, out_valid_d;
   logic [CNT_W-1:0]   free_count_q, free_count_d;
   logic               full_q, full_d;

   for (genvar i = 0; i < RS_SIZE; i++) begin : g_entry
      rs_entry #(.NUM_CDB(NUM_CDB)) u_entry (
         .clock        (clock),
         .reset        (reset),
         .clear_i      (clear[i]),
         .load_i       (load[i]),
         .load_entry_i (load_entry[i]),
         .cdb_data_i   (rs_cdb_in),
         .cdb_tag_i    (rs_cdb_tag),
         .cdb_valid_i  (rs_cdb_valid),
         .entry_o      (entries[i]),
         .ready_o      (ready[i])
      );
   end

   // Lowest and second-lowest empty slots; a slot being issued this cycle still counts as occupied.
   always_comb begin
      free_found  = '0;
      free_idx[0] = '0;
      free_idx[1] = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (!entries[i].valid) begin
            if (!free_found[0]) begin
               free_found[0] = 1'b1;
               free_idx[0]   = IDX_W'(i);
            end else if (!free_found[1]) begin
               free_found[1] = 1'b1;
               free_idx[1]   = IDX_W'(i);
            end
         end
      end
   end

   always_comb begin
      for (int l = 0; l < 2; l++) begin
         lane_entry[l]          = '0;
         lane_entry[l].valid    = 1'b1;
         lane_entry[l].opa      = rs_opa_in[l];
         lane_entry[l].opa_rdy  = rs_opa_valid[l];
         lane_entry[l].opb      = rs_opb_in[l];
         lane_entry[l].opb_rdy  = rs_opb_valid[l];
         lane_entry[l].dest     = rs_dest_in[l];
         lane_entry[l].rob_idx  = rs_rob_idx_in[l];
         lane_entry[l].op_type  = rs_op_type_in[l];
         lane_entry[l].alu_func = rs_alu_func[l];
         lane_entry[l].fu_sel   = fu_class_e'(2'(rs_fu_sel_in[l]));
      end
   end

   // Issue select works only on registered state, so a wakeup or dispatch is seen one edge later.
   always_comb begin
      sel_found  = '0;
      issue_mask = '0;
      for (int f = 0; f < NUM_FU; f++) begin
         sel_idx[f] = '0;
         for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i] && fu_available[f] && (int'(entries[i].fu_sel) == f)) begin
               sel_found[f] = 1'b1;
               sel_idx[f]   = IDX_W'(i);
            end
         end
         if (sel_found[f]) begin
            issue_mask[sel_idx[f]] = 1'b1;
         end
      end
   end

   always_comb begin
      dispatch_ok = !full_q && !squash;
      lane_go[0]  = dispatch_ok && rs_load_in[0] && free_found[0];
      lane_go[1]  = dispatch_ok && rs_load_in[1] && free_found[1];
      for (int i = 0; i < RS_SIZE; i++) begin
         load[i]       = (lane_go[0] && (free_idx[0] == IDX_W'(i)))
                      || (lane_go[1] && (free_idx[1] == IDX_W'(i)));
         load_entry[i] = (lane_go[0] && (free_idx[0] == IDX_W'(i))) ? lane_entry[0] : lane_entry[1];
         clear[i]      = squash || issue_mask[i];
      end
   end

   always_comb begin
      free_count_d = free_count_q;
      for (int f = 0; f < NUM_FU; f++) begin
         if (sel_found[f]) begin
            free_count_d = free_count_d + CNT_W'(1);
         end
      end
      for (int l = 0; l < 2; l++) begin
         if (lane_go[l]) begin
            free_count_d = free_count_d - CNT_W'(1);
         end
      end
      out_valid_d = sel_found;
      if (squash) begin
         free_count_d = CNT_W'(RS_SIZE);
         out_valid_d  = '0;
      end
      full_d = free_count_d < CNT_W'(2);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_q  <= '0;
         free_count_q <= CNT_W'(RS_SIZE);
         full_q       <= 1'b0;
         for (int f = 0; f < NUM_FU; f++) begin
            opa_q[f]      <= '0;
            opb_q[f]      <= '0;
            dest_q[f]     <= '0;
            rob_q[f]      <= '0;
            op_type_q[f]  <= '0;
            alu_func_q[f] <= ALU_ADD;
         end
      end else begin
         out_valid_q  <= out_valid_d;
         free_count_q <= free_count_d;
         full_q       <= full_d;
         for (int f = 0; f < NUM_FU; f++) begin
            if (sel_found[f]) begin
               opa_q[f]      <= entries[sel_idx[f]].opa;
               opb_q[f]      <= entries[sel_idx[f]].opb;
               dest_q[f]     <= entries[sel_idx[f]].dest;
               rob_q[f]      <= entries[sel_idx[f]].rob_idx;
               op_type_q[f]  <= entries[sel_idx[f]].op_type;
               alu_func_q[f] <= entries[sel_idx[f]].alu_func;
            end
         end
      end
   end

   assign rs_opa_out      = opa_q;
   assign rs_opb_out      = opb_q;
   assign rs_dest_tag_out = dest_q;
   assign rs_rob_idx_out  = rob_q;
   assign rs_op_type_out  = op_type_q;
   assign rs_alu_func_out = alu_func_q;
   assign rs_out_valid    = out_valid_q;
   assign rs_free_count   = free_count_q;
   assign rs_full         = full_q;

endmodule
